// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the shared register-file write port: picks one of four
// requesters per cycle and registers the winning write in a one-entry output slot.
module wb_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter bit DROP_ZERO = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [3:0]            req_valid,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*DATA_W-1:0]   req_data,
    output logic [3:0]            req_ready,
    output logic [1:0]            mux_sel,
    output logic                  out_valid,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready
);

    // First valid requester scanning upward from ptr, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + k[1:0];
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    logic                 out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]    out_addr_q,  out_addr_d;
    logic [DATA_W-1:0]    out_data_q,  out_data_d;
    logic [1:0]           ptr_q,       ptr_d;
    logic [1:0]           last_sel_q,  last_sel_d;

    logic                 can_load_s;
    logic                 any_valid_s;
    logic                 transfer_s;
    logic [1:0]           grant_s;
    logic [ADDR_W-1:0]    win_addr_s;
    logic [DATA_W-1:0]    win_data_s;

    // Arbitration decision and the winner's address/data selection.
    always_comb begin
        can_load_s  = !out_valid_q || out_ready;
        any_valid_s = |req_valid;
        grant_s     = rr_pick(req_valid, ptr_q);
        transfer_s  = can_load_s && any_valid_s && !Reset;
        win_addr_s  = '0;
        win_data_s  = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant_s == i[1:0]) begin
                win_addr_s = req_addr[ADDR_W*i +: ADDR_W];
                win_data_s = req_data[DATA_W*i +: DATA_W];
            end else begin
                win_addr_s = win_addr_s;
            end
        end
    end

    // Grant and external mux select; the out_ready -> req_ready path is combinational.
    always_comb begin
        if (transfer_s) begin
            req_ready = 4'b0001 << grant_s;
        end else begin
            req_ready = 4'b0000;
        end
        if (any_valid_s) begin
            mux_sel = grant_s;
        end else begin
            mux_sel = last_sel_q;
        end
    end

    // Next state of the output slot and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
        last_sel_d  = last_sel_q;
        if (transfer_s) begin
            out_addr_d  = win_addr_s;
            out_data_d  = win_data_s;
            ptr_d       = grant_s + 2'd1;
            last_sel_d  = grant_s;
            // Register 0 writes are acknowledged but leave the slot empty.
            out_valid_d = !(DROP_ZERO && (win_addr_s == '0));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            ptr_q       <= 2'd0;
            last_sel_q  <= 2'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
            last_sel_q  <= last_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios followed by randomized
// traffic, checked against a queue-based round-robin reference model.
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                 Clk;
    logic                 Reset;
    logic [3:0]           req_valid;
    logic [4*ADDR_W-1:0]  req_addr;
    logic [4*DATA_W-1:0]  req_data;
    logic [3:0]           req_ready;
    logic [1:0]           mux_sel;
    logic                 out_valid;
    logic [ADDR_W-1:0]    out_addr;
    logic [DATA_W-1:0]    out_data;
    logic                 out_ready;

    logic [ADDR_W-1:0]    tb_addr [4];
    logic [DATA_W-1:0]    tb_data [4];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Reference model state
    int       m_ptr      = 0;
    int       m_last_sel = 0;
    bit       m_full     = 1'b0;
    bit       m_after_rst = 1'b0;
    bit [3:0] ack_mask   = 4'b0000;
    bit [3:0] pend       = 4'b0000;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_ZERO(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .mux_sel(mux_sel),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
        .out_ready(out_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[ADDR_W*i +: ADDR_W] = tb_addr[i];
            req_data[DATA_W*i +: DATA_W] = tb_data[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: slot occupancy and contents against the scoreboard queue.
    always @(negedge Clk) begin
        check("out_valid", {63'd0, out_valid}, {63'd0, (exp_q.size() != 0)});
        if (out_valid === 1'b1 && exp_q.size() != 0) begin
            check("out_addr", {59'd0, out_addr}, {59'd0, exp_q[0].addr});
            check("out_data", {32'd0, out_data}, {32'd0, exp_q[0].data});
            if (out_ready) void'(exp_q.pop_front());
        end
    end

    // Reference model: evaluated once per cycle with inputs stable, before the edge.
    task automatic model_step();
        bit [3:0] exp_rdy;
        int       g;
        bit       any;
        bit       can_load;
        wr_t      w;
        if (m_after_rst) begin
            check("rst_out_addr", {59'd0, out_addr}, 64'd0);
            check("rst_out_data", {32'd0, out_data}, 64'd0);
            m_after_rst = 1'b0;
        end
        if (Reset) begin
            check("req_ready_rst", {60'd0, req_ready}, 64'd0);
            ack_mask    = 4'b0000;
            m_ptr       = 0;
            m_last_sel  = 0;
            m_full      = 1'b0;
            m_after_rst = 1'b1;
            exp_q.delete();
            return;
        end
        any = (req_valid != 4'b0000);
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
        can_load = !m_full || out_ready;
        exp_rdy  = (can_load && any) ? (4'b0001 << g) : 4'b0000;
        check("req_ready", {60'd0, req_ready}, {60'd0, exp_rdy});
        check("mux_sel", {62'd0, mux_sel}, any ? 64'(g) : 64'(m_last_sel));
        ack_mask = exp_rdy;
        if (can_load && any) begin
            w.addr = tb_addr[g];
            w.data = tb_data[g];
            if (w.addr == 5'd0) begin
                m_full = 1'b0;
            end else begin
                m_full = 1'b1;
                exp_q.push_back(w);
            end
            m_ptr      = (g + 1) % 4;
            m_last_sel = g;
        end else if (can_load && out_ready) begin
            m_full = 1'b0;
        end
    endtask

    task automatic step_cycle();
        @(negedge Clk);
        #1;
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rv, input logic ordy, input logic rst);
        req_valid = rv;
        out_ready = ordy;
        Reset     = rst;
        step_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            tb_addr[i] = 5'(i + 1);
            tb_data[i] = 32'hA000_0000 + 32'(i);
        end
        req_valid = 4'b1111;
        out_ready = 1'b1;
        Reset     = 1'b1;

        // Reset with all requesters valid, then round-robin under full contention
        drive(4'b1111, 1'b1, 1'b1);
        drive(4'b1111, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) drive(4'b1111, 1'b1, 1'b0);

        // Stalled slot holds, then the next winner is acked as the slot drains
        for (int c = 0; c < 6; c++) drive(4'b1111, 1'b0, 1'b0);
        drive(4'b1111, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);

        // Write to register 0 is acked and dropped; pointer still advances
        tb_addr[2] = 5'd0;
        tb_data[2] = 32'hDEADBEEF;
        drive(4'b0100, 1'b1, 1'b0);
        tb_addr[2] = 5'd3;
        drive(4'b1001, 1'b1, 1'b0);

        // ptr=2 with requesters 1 and 3 alternating
        drive(4'b0010, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) drive(4'b1010, 1'b1, 1'b0);

        // Reset while the slot is stalled
        tb_addr[0] = 5'd7;
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b1000, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b0);

        // Randomized traffic; each requester holds its write until acknowledged
        pend     = 4'b0000;
        ack_mask = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (ack_mask[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i]    = 1'b1;
                    tb_addr[i] = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
                    tb_data[i] = $urandom();
                end
            end
            drive(pend, ($urandom_range(3, 0) != 0), ($urandom_range(49, 0) == 0));
        end

        for (int c = 0; c < 3; c++) drive(4'b0000, 1'b1, 1'b0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
